ula_acc_stk: RTL
================

# ula_acc_stk

Accumulator and operand-stack stage directly downstream of the processor ALU. Captures the ALU result word and its zero flag into the accumulator, which feeds back as the ALU's second operand. Holds a LIFO of spilled accumulator values whose top word serves as the ALU's first operand for stack-based expressions. All words use the ALU's float format: 1 sign bit, EXP exponent bits, MAN mantissa bits.

## Interface

Parameters:
- EXP, 8, exponent width; word width is MAN+EXP+1
- MAN, 23, mantissa width
- SDEPTH, 16, stack depth in words; power of two, 2..256
- SPW, 4, stack pointer width; equals log2(SDEPTH)

Ports:
- clk  in  1  system clock, all state changes on rising edge
- rst  in  1  reset, synchronous, active-low
- acc_ld  in  1  load accumulator from ula_out / ula_iz this cycle
- ula_out  in  MAN+EXP+1  ALU result word
- ula_iz  in  1  ALU is_zero flag for ula_out
- push  in  1  push current accumulator value onto stack
- pop  in  1  discard top of stack
- acc  out  MAN+EXP+1  accumulator value (to ALU in2)
- acc_iz  out  1  registered zero flag of acc
- stk_top  out  MAN+EXP+1  top-of-stack word (to ALU in1 mux)
- stk_cnt  out  SPW+1  number of valid stack entries, 0..SDEPTH
- stk_full  out  1  stk_cnt == SDEPTH
- stk_empty  out  1  stk_cnt == 0
- stk_ovf  out  1  sticky: push attempted while full
- stk_udf  out  1  sticky: pop attempted while empty

## Operation

- Reset (rst low at an edge): acc = 0, acc_iz = 1, stk_cnt = 0, stk_ovf = 0, stk_udf = 0. Stack RAM is not cleared. rst dominates every other input in the same cycle.
- Accumulator:
  - acc_ld high: acc <= ula_out and acc_iz <= ula_iz.
  - acc_ld low: both hold.
  - acc_iz is taken from the ALU flag, never recomputed locally.
- Stack storage: RAM of SDEPTH words.
  - Entry i is written at address i.
  - stk_top = RAM[stk_cnt-1], read combinationally.
  - stk_top = 0 when stk_cnt == 0.
- Push only (push=1, pop=0):
  - Not full: RAM[stk_cnt] <= acc (value before any same-cycle acc_ld), stk_cnt + 1.
  - Full: no write, stk_cnt holds, stk_ovf <= 1.
- Pop only (push=0, pop=1):
  - Not empty: stk_cnt - 1; RAM untouched.
  - Empty: stk_cnt holds, stk_udf <= 1.
- Push and pop together (swap-top):
  - Not empty: RAM[stk_cnt-1] <= acc (pre-load value), stk_cnt unchanged. Valid even when full; no ovf.
  - Empty: no write, stk_cnt holds, stk_udf <= 1.
- acc_ld combined with push: stack receives the old acc, acc receives ula_out. This supports "spill then compute" in one instruction.
- stk_full and stk_empty decode from stk_cnt combinationally.
- stk_ovf and stk_udf clear only on reset.

## Timing

- acc, acc_iz, stk_cnt, stk_ovf, stk_udf: registered, updated at the edge where the controlling input is high; visible the following cycle.
- stk_top, stk_full, stk_empty: combinational from registered state, so they also reflect changes one cycle after push or pop.
- Read-after-push: the pushed value is visible on stk_top in the cycle immediately after the push edge. No bypass is needed because stk_top reads post-edge RAM.
- Zero-latency feedback: acc drives ALU in2 with no extra stage. ALU result to acc is one cycle.
- Back-to-back push, pop or swap are accepted every cycle, with no stall and no handshake. The controller is responsible for avoiding ovf/udf; the flags exist for debug.
- Wrap-around is forbidden: stk_cnt saturates at 0 and SDEPTH.

## Test plan

- Reset: hold rst low 2 cycles with acc_ld=1, ula_out=0x40A00000 -> after release acc=0, acc_iz=1, stk_cnt=0, stk_empty=1, stk_ovf=0, stk_udf=0.
- Load + push same cycle:
  - Setup: acc=0x3F800000, then drive acc_ld=1, push=1, ula_out=0x40000000, ula_iz=0.
  - Next cycle: acc=0x40000000, stk_top=0x3F800000, stk_cnt=1.
- Fill and overflow:
  - Push SDEPTH distinct values 1..16 -> stk_full=1, stk_top=16.
  - One more push -> stk_cnt stays 16, stk_top stays 16, stk_ovf=1.
- Drain and underflow:
  - From full, pop 16 times -> stk_top follows 15..1, then 0; stk_empty=1.
  - Extra pop -> stk_cnt=0, stk_udf=1, stk_ovf keeps prior value.
- Swap-top:
  - Stack [0xA, 0xB], acc=0xC, push=1, pop=1 -> stk_cnt=2, stk_top=0xC.
  - Then pop -> stk_top=0xA.
  - Swap when empty -> stk_udf=1, stk_cnt=0.
- Mid-operation reset: stk_cnt=5, assert rst with push=1 -> stk_cnt=0, stk_top=0, stk_ovf=0 next cycle.

Source files
------------

// File: rtl/ula_acc_stk_if.sv
// ula_acc_stk_if: control, ALU data and stack status bundle for the accumulator/stack stage
interface ula_acc_stk_if #(parameter int EXP = 8, MAN = 23, SPW = 4);
  localparam int W = MAN + EXP + 1;
  logic         acc_ld;
  logic [W-1:0] ula_out;
  logic         ula_iz;
  logic         push;
  logic         pop;
  logic [W-1:0] acc;
  logic         acc_iz;
  logic [W-1:0] stk_top;
  logic [SPW:0] stk_cnt;
  logic         stk_full;
  logic         stk_empty;
  logic         stk_ovf;
  logic         stk_udf;
  modport master(output acc_ld, ula_out, ula_iz, push, pop,
                 input acc, acc_iz, stk_top, stk_cnt, stk_full, stk_empty, stk_ovf, stk_udf);
  modport slave(input acc_ld, ula_out, ula_iz, push, pop,
                output acc, acc_iz, stk_top, stk_cnt, stk_full, stk_empty, stk_ovf, stk_udf);
endinterface

// File: rtl/ula_acc_stk.sv
// ula_acc_stk: ALU result accumulator plus LIFO spill stack supplying both ALU operands
module ula_acc_stk #(
  parameter int EXP = 8,
  parameter int MAN = 23,
  parameter int SDEPTH = 16,
  parameter int SPW = 4
) (
  input logic clk,
  input logic rst,
  ula_acc_stk_if.slave bus
);
  localparam int W = MAN + EXP + 1;
  logic [W-1:0] mem [SDEPTH];
  logic [W-1:0] acc;
  logic acc_iz, ovf, udf, full, empty, wr, ovf_set, udf_set;
  logic [SPW:0] cnt, cnt_nxt, cnt_m1;
  logic [SPW-1:0] wr_addr;
  assign cnt_m1 = cnt - (SPW+1)'(1);
  assign full = cnt == (SPW+1)'(SDEPTH);
  assign empty = cnt == '0;
  // push+pop together rewrites the current top in place (swap-top)
  assign wr = bus.push & (bus.pop ? !empty : !full);
  assign wr_addr = bus.pop ? cnt_m1[SPW-1:0] : cnt[SPW-1:0];
  assign ovf_set = bus.push & !bus.pop & full;
  assign udf_set = bus.pop & empty;
  assign cnt_nxt = (bus.push & !bus.pop & !full) ? cnt + (SPW+1)'(1) :
                   (bus.pop & !bus.push & !empty) ? cnt_m1 : cnt;
  always_ff @(posedge clk) begin
    if (!rst) begin
      acc <= '0;
      acc_iz <= 1'b1;
      cnt <= '0;
      ovf <= 1'b0;
      udf <= 1'b0;
    end else begin
      if (bus.acc_ld) begin
        acc <= bus.ula_out;
        acc_iz <= bus.ula_iz;
      end
      cnt <= cnt_nxt;
      ovf <= ovf | ovf_set;
      udf <= udf | udf_set;
    end
  end
  always_ff @(posedge clk) if (rst && wr) mem[wr_addr] <= acc;
  assign bus.acc = acc;
  assign bus.acc_iz = acc_iz;
  assign bus.stk_top = empty ? '0 : mem[cnt_m1[SPW-1:0]];
  assign bus.stk_cnt = cnt;
  assign bus.stk_full = full;
  assign bus.stk_empty = empty;
  assign bus.stk_ovf = ovf;
  assign bus.stk_udf = udf;
endmodule
